volume_meter: RTL and testbench

VOLUME_METER -- requirements
Module: volume_meter

---
 rtl/volume_meter.sv | 121 ++++++++++++
 tb/tb_volume_meter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/volume_meter.sv
// Microphone loudness meter: peak-detects |mic_in - MIDPOINT| (positive half only) over
// WINDOW accepted samples and maps the peak to a 0..16 level. Define VOLUME_METER_SMOOTH_EN
// to output the mean of the last four window levels instead of the raw level.
module volume_meter #(
  parameter int unsigned WINDOW   = 4000,
  parameter logic [11:0] MIDPOINT = 12'd2048
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] mic_in,
  input  logic        sample_valid,
  input  logic        hold,
  output logic [4:0]  volume,
  output logic        volume_valid,
  output logic [10:0] peak
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned AMP_W = 11;
  localparam int unsigned LVL_W = 5;
  localparam logic [CNT_W-1:0] WIN_CNT = CNT_W'(WINDOW);

  typedef enum logic {ACCUM, UPDATE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt, cnt_inc;
  logic [AMP_W-1:0]   run_peak, run_peak_nxt;
  logic [AMP_W-1:0]   peak_nxt, amp, max_pk;
  logic [LVL_W-1:0]   level, volume_nxt, new_volume;
  logic               volume_valid_nxt;

`ifdef VOLUME_METER_SMOOTH_EN
  localparam int unsigned SUM_W = LVL_W + 2;
  logic [LVL_W-1:0] hist0, hist1, hist2;
  logic [LVL_W-1:0] hist0_nxt, hist1_nxt, hist2_nxt;
  logic [SUM_W-1:0] level_sum;
`endif

  // Only the positive excursion above the DC offset counts as loudness
  assign amp     = (mic_in > MIDPOINT) ? AMP_W'(mic_in - MIDPOINT) : '0;
  assign max_pk  = (amp > run_peak) ? amp : run_peak;
  assign cnt_inc = CNT_W'(cnt + CNT_W'(1));
  assign level   = (max_pk == '0) ? '0 : LVL_W'(max_pk >> 7) + LVL_W'(1);

`ifdef VOLUME_METER_SMOOTH_EN
  assign level_sum  = SUM_W'(level) + SUM_W'(hist0) + SUM_W'(hist1) + SUM_W'(hist2);
  assign new_volume = LVL_W'(level_sum >> 2);
`else
  assign new_volume = level;
`endif

  // Next-state and registered-output logic; outputs load on the completing sample
  // so they change one clock after it, while UPDATE blanks the following cycle.
  always_comb begin
    state_nxt        = state;
    cnt_nxt          = cnt;
    run_peak_nxt     = run_peak;
    peak_nxt         = peak;
    volume_nxt       = volume;
    volume_valid_nxt = 1'b0;
`ifdef VOLUME_METER_SMOOTH_EN
    hist0_nxt        = hist0;
    hist1_nxt        = hist1;
    hist2_nxt        = hist2;
`endif
    case (state)
      ACCUM: begin
        if (sample_valid && !hold) begin
          if (cnt_inc == WIN_CNT) begin
            peak_nxt         = max_pk;
            volume_nxt       = new_volume;
            volume_valid_nxt = 1'b1;
            run_peak_nxt     = '0;
            cnt_nxt          = '0;
            state_nxt        = UPDATE;
`ifdef VOLUME_METER_SMOOTH_EN
            hist0_nxt        = level;
            hist1_nxt        = hist0;
            hist2_nxt        = hist1;
`endif
          end else begin
            run_peak_nxt = max_pk;
            cnt_nxt      = cnt_inc;
          end
        end
      end
      UPDATE: begin
        state_nxt = ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ACCUM;
      cnt          <= '0;
      run_peak     <= '0;
      peak         <= '0;
      volume       <= '0;
      volume_valid <= 1'b0;
`ifdef VOLUME_METER_SMOOTH_EN
      hist0        <= '0;
      hist1        <= '0;
      hist2        <= '0;
`endif
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      run_peak     <= run_peak_nxt;
      peak         <= peak_nxt;
      volume       <= volume_nxt;
      volume_valid <= volume_valid_nxt;
`ifdef VOLUME_METER_SMOOTH_EN
      hist0        <= hist0_nxt;
      hist1        <= hist1_nxt;
      hist2        <= hist2_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_volume_meter.sv
// Self-checking bench for volume_meter (WINDOW=4, MIDPOINT=2048); a queue-based window
// model is compared every cycle, plus hand-computed literal expectations.
module tb_volume_meter;

  localparam int unsigned WINDOW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] mic_in = 12'd0;
  logic        sample_valid = 1'b0;
  logic        hold = 1'b0;
  logic [4:0]  volume;
  logic        volume_valid;
  logic [10:0] peak;

  int checks = 0;
  int failures = 0;

  volume_meter #(.WINDOW(WINDOW), .MIDPOINT(12'd2048)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mic_in       (mic_in),
    .sample_valid (sample_valid),
    .hold         (hold),
    .volume       (volume),
    .volume_valid (volume_valid),
    .peak         (peak)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Window model: collect accepted amplitudes, evaluate when WINDOW of them exist
  int window_amps[$];
  int lvl_hist[$];
  bit in_update = 1'b0;
  int exp_volume = 0;
  int exp_peak = 0;
  bit exp_valid = 1'b0;
  int mx, lvl, sum;

  function automatic int amp_of(input int s);
    return (s > 2048) ? s - 2048 : 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      window_amps.delete();
      lvl_hist.delete();
      in_update  = 1'b0;
      exp_volume = 0;
      exp_peak   = 0;
      exp_valid  = 1'b0;
    end else begin
      exp_valid = 1'b0;
      if (in_update) begin
        in_update = 1'b0;
      end else if (sample_valid && !hold) begin
        window_amps.push_back(amp_of(int'(mic_in)));
        if (window_amps.size() == WINDOW) begin
          mx = 0;
          foreach (window_amps[i]) if (window_amps[i] > mx) mx = window_amps[i];
          lvl = (mx == 0) ? 0 : mx / 128 + 1;
          exp_peak = mx;
`ifdef VOLUME_METER_SMOOTH_EN
          lvl_hist.push_front(lvl);
          if (lvl_hist.size() > 4) void'(lvl_hist.pop_back());
          sum = 0;
          foreach (lvl_hist[i]) sum += lvl_hist[i];
          exp_volume = sum / 4;
`else
          exp_volume = lvl;
`endif
          exp_valid = 1'b1;
          in_update = 1'b1;
          window_amps.delete();
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  bit prev_valid = 1'b0;
  always @(negedge clk) begin
    chk("cyc_volume", int'(volume), exp_volume);
    chk("cyc_peak", int'(peak), exp_peak);
    chk("cyc_valid", int'(volume_valid), int'(exp_valid));
    chk("valid_not_back_to_back", int'(prev_valid && volume_valid), 0);
    chk("volume_range", int'(volume > 5'd16), 0);
    prev_valid = volume_valid;
  end

  task automatic step(input int m, input bit v, input bit h);
    @(negedge clk);
    mic_in       = 12'(m);
    sample_valid = v;
    hold         = h;
  endtask

  task automatic window_of(input int m);
    repeat (WINDOW) step(m, 1'b1, 1'b0);
    step(0, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_volume", int'(volume), 0);
    chk("reset_peak", int'(peak), 0);
    chk("reset_valid", int'(volume_valid), 0);
    rst_n = 1'b1;

`ifndef VOLUME_METER_SMOOTH_EN
    // Mixed window
    step(2048, 1, 0); step(2100, 1, 0); step(3000, 1, 0); step(2500, 1, 0);
    step(0, 0, 0);
    chk("mixed_valid", int'(volume_valid), 1);
    chk("mixed_peak", int'(peak), 952);
    chk("mixed_volume", int'(volume), 8);
    step(0, 0, 0);
    chk("mixed_pulse_once", int'(volume_valid), 0);

    // Below midpoint
    window_of(1000);
    chk("low_valid", int'(volume_valid), 1);
    chk("low_peak", int'(peak), 0);
    chk("low_volume", int'(volume), 0);

    // Full scale then silence
    window_of(4095);
    chk("full_peak", int'(peak), 2047);
    chk("full_volume", int'(volume), 16);
    window_of(2048);
    chk("silent_volume", int'(volume), 0);

    // Hold across samples 2 and 3
    step(2148, 1, 0); step(2148, 1, 1); step(2148, 1, 1);
    step(2148, 1, 0); step(2148, 1, 0); step(0, 0, 0);
    chk("hold_no_update", int'(volume_valid), 0);
    step(2148, 1, 0);
    step(4095, 1, 0);  // lands in the UPDATE cycle and must be dropped
    chk("hold_valid", int'(volume_valid), 1);
    chk("hold_peak", int'(peak), 100);
    chk("hold_volume", int'(volume), 1);
    step(2248, 1, 0); step(2248, 1, 0); step(2248, 1, 0); step(0, 0, 0);
    chk("update_drop_not_counted", int'(volume_valid), 0);
    step(2248, 1, 0); step(0, 0, 0);
    chk("after_drop_valid", int'(volume_valid), 1);
    chk("after_drop_peak", int'(peak), 200);
    chk("after_drop_volume", int'(volume), 2);

    // Hold coincident with the completing sample
    step(2148, 1, 0); step(2148, 1, 0); step(2148, 1, 0);
    step(4095, 1, 1); step(0, 0, 0);
    chk("hold_wins_no_update", int'(volume_valid), 0);
    step(2348, 1, 0); step(0, 0, 0);
    chk("hold_wins_valid", int'(volume_valid), 1);
    chk("hold_wins_peak", int'(peak), 300);
    chk("hold_wins_volume", int'(volume), 3);

    // Reset mid-window
    step(4095, 1, 0); step(4095, 1, 0); step(4095, 1, 0); step(0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_volume", int'(volume), 0);
    chk("midreset_peak", int'(peak), 0);
    step(0, 0, 0);
    #2 rst_n = 1'b1;
    step(4095, 1, 0); step(0, 0, 0);
    chk("postreset_no_update", int'(volume_valid), 0);
    step(4095, 1, 0); step(4095, 1, 0); step(0, 0, 0);
    chk("postreset_still_none", int'(volume_valid), 0);
    step(4095, 1, 0); step(0, 0, 0);
    chk("postreset_valid", int'(volume_valid), 1);
    chk("postreset_volume", int'(volume), 16);
`else
    // Smoothed levels ramp against zeroed history
    window_of(4095);
    chk("smooth_1", int'(volume), 4);
    window_of(4095);
    chk("smooth_2", int'(volume), 8);
    window_of(4095);
    chk("smooth_3", int'(volume), 12);
    window_of(4095);
    chk("smooth_4", int'(volume), 16);
    chk("smooth_peak_raw", int'(peak), 2047);
`endif

    repeat (3) step(0, 0, 0);
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
